// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweeper and its test harness.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [7:0] S_GOLDEN = 8'h6A;

    function automatic int unsigned table_width(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage

// File: rtl/s_module_with_wires.sv
// Combinational s-function gate block: s = z ^ (x & y), truth table 8'h6A over {x,y,z}.
module s_module_with_wires (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s
);

    logic xy_and;

    assign xy_and = x & y;
    assign s      = xy_and ^ z;

endmodule

// File: rtl/s_truth_table_sweeper.sv
// Sweeps every {x,y,z} vector into the gate block, captures s into a truth table,
// and reports the table plus a golden-match flag over a done/ack handshake.
module s_truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int unsigned                   N_IN          = 3,
    parameter int unsigned                   SETTLE_CYCLES = 1,
    parameter logic [table_width(N_IN)-1:0]  EXPECTED      = S_GOLDEN
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          x,
    output logic                          y,
    output logic                          z,
    input  logic                          s_in,
    output logic                          busy,
    output logic                          done,
    input  logic                          ack,
    output logic [table_width(N_IN)-1:0]  table_out,
    output logic                          match
);

    localparam int unsigned     TW          = table_width(N_IN);
    localparam int unsigned     CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] IDX_LAST    = '1;

    state_t          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [CW-1:0]   settle_cnt_q, settle_cnt_d;
    logic [TW-1:0]   table_q, table_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        settle_cnt_d = settle_cnt_q;
        table_d      = table_q;
        busy_d       = busy_q;
        done_d       = done_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = DRIVE;
                    idx_d        = '0;
                    settle_cnt_d = '0;
                    table_d      = '0;
                    busy_d       = 1'b1;
                end
            end
            DRIVE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                table_d[idx_q] = s_in;
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    // idx feeds x/y/z directly, so the vector only moves here
                    idx_d        = idx_q + 1'b1;
                    settle_cnt_d = '0;
                    state_d      = DRIVE;
                end
            end
            DONE: begin
                if (ack) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            settle_cnt_q <= '0;
            table_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            settle_cnt_q <= settle_cnt_d;
            table_q      <= table_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign x         = idx_q[2];
    assign y         = idx_q[1];
    assign z         = idx_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign match     = done_q && (table_q == EXPECTED);

endmodule

// File: tb/tb_s_truth_table_sweeper.sv
// Bench for s_truth_table_sweeper driving the s-function gate block (settle 1 and settle 3 builds).
module tb_s_truth_table_sweeper;
    import sweep_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start_a, ack_a, start_b, ack_b;
    logic       x_a, y_a, z_a, s_a, s_gate_a, busy_a, done_a, match_a;
    logic       x_b, y_b, z_b, s_gate_b, busy_b, done_b, match_b;
    logic [7:0] table_a, table_b;
    int         mode;
    bit         sel;

    // mode 0: real gate, 1: stuck-at-0 model, 2: real gate with vector 6 inverted
    always_comb begin
        case (mode)
            1:       s_a = 1'b0;
            2:       s_a = s_gate_a ^ ({x_a, y_a, z_a} == 3'd6);
            default: s_a = s_gate_a;
        endcase
    end

    s_module_with_wires gate_a (.x(x_a), .y(y_a), .z(z_a), .s(s_gate_a));
    s_module_with_wires gate_b (.x(x_b), .y(y_b), .z(z_b), .s(s_gate_b));

    s_truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(1), .EXPECTED(8'h6A)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .x(x_a), .y(y_a), .z(z_a),
        .s_in(s_a), .busy(busy_a), .done(done_a), .ack(ack_a),
        .table_out(table_a), .match(match_a)
    );

    s_truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(3), .EXPECTED(8'h6A)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .x(x_b), .y(y_b), .z(z_b),
        .s_in(s_gate_b), .busy(busy_b), .done(done_b), .ack(ack_b),
        .table_out(table_b), .match(match_b)
    );

    logic       cur_busy, cur_done, cur_match;
    logic [2:0] cur_vec;
    logic [7:0] cur_table;
    assign cur_busy  = sel ? busy_b  : busy_a;
    assign cur_done  = sel ? done_b  : done_a;
    assign cur_match = sel ? match_b : match_a;
    assign cur_table = sel ? table_b : table_a;
    assign cur_vec   = sel ? {x_b, y_b, z_b} : {x_a, y_a, z_a};

    typedef struct packed {
        logic [7:0] tab;
        logic       m;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        bit         inst;
        int         mode;
        logic [7:0] tab;
        bit         m;
        int         hold;
        int         lat;
        int         poke;
    } vec_t;
    vec_t vecs[5];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start(input bit b);
        @(negedge clk);
        sel = b;
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Called on the first falling edge after acceptance; poke_at drives start+ack mid-sweep.
    task automatic run_to_done(input bit b, input int hold, input int exp_lat, input int poke_at);
        int   k;
        exp_t e;
        k = 0;
        check("busy_on_accept", cur_busy, 1);
        while (cur_done !== 1'b1 && k < 200) begin
            if (k < exp_lat) check("vector_order", cur_vec, k / hold);
            if (k == poke_at) begin
                if (b) begin start_b = 1'b1; ack_b = 1'b1; end
                else   begin start_a = 1'b1; ack_a = 1'b1; end
            end else begin
                start_a = 1'b0; ack_a = 1'b0; start_b = 1'b0; ack_b = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start_a = 1'b0; ack_a = 1'b0; start_b = 1'b0; ack_b = 1'b0;
        check("done_latency", k, exp_lat);
        check("busy_at_done", cur_busy, 0);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
        end else begin
            e = sb_q.pop_front();
            check("table_out", cur_table, e.tab);
            check("match", cur_match, e.m);
        end
    endtask

    task automatic ack_result(input bit b);
        if (b) ack_b = 1'b1; else ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        ack_b = 1'b0;
        check("done_after_ack", cur_done, 0);
        check("busy_after_ack", cur_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 0, 8'h6A, 1'b1, 2, 16, -1};
        vecs[1] = '{1'b0, 1, 8'h00, 1'b0, 2, 16, -1};
        vecs[2] = '{1'b0, 2, 8'h2A, 1'b0, 2, 16, -1};
        vecs[3] = '{1'b0, 0, 8'h6A, 1'b1, 2, 16,  5};
        vecs[4] = '{1'b1, 0, 8'h6A, 1'b1, 4, 32, -1};

        rst_n = 1'b0; start_a = 1'b0; ack_a = 1'b0; start_b = 1'b0; ack_b = 1'b0;
        mode = 0; sel = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_match", match_a, 0);
        check("rst_table", table_a, 0);
        check("rst_vec", {x_a, y_a, z_a}, 0);
        check("rst_busy_b", busy_b, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            mode = vecs[i].mode;
            sb_q.push_back('{tab: vecs[i].tab, m: vecs[i].m});
            pulse_start(vecs[i].inst);
            run_to_done(vecs[i].inst, vecs[i].hold, vecs[i].lat, vecs[i].poke);
            ack_result(vecs[i].inst);
        end

        // Result held without ack; a start pulse while done must be ignored.
        mode = 0;
        sb_q.push_back('{tab: 8'h6A, m: 1'b1});
        pulse_start(1'b0);
        run_to_done(1'b0, 2, 16, -1);
        for (int c = 0; c < 10; c++) begin
            start_a = (c == 3);
            @(negedge clk);
            check("hold_done", done_a, 1);
            check("hold_table", table_a, 8'h6A);
            check("hold_match", match_a, 1);
        end
        start_a = 1'b0;

        // ack and start together in DONE: ack wins, no restart.
        ack_a = 1'b1; start_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0; start_a = 1'b0;
        check("ackstart_done", done_a, 0);
        check("ackstart_busy", busy_a, 0);
        @(negedge clk);
        check("ackstart_no_restart", busy_a, 0);
        check("ackstart_no_clear", table_a, 8'h6A);

        // Reset mid-sweep at cycle 9 aborts and discards the partial table.
        sb_q.push_back('{tab: 8'h6A, m: 1'b1});
        pulse_start(1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_match", match_a, 0);
        check("abort_table", table_a, 0);
        check("abort_vec", {x_a, y_a, z_a}, 0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_done", done_a, 0);

        sb_q.push_back('{tab: 8'h6A, m: 1'b1});
        pulse_start(1'b0);
        run_to_done(1'b0, 2, 16, -1);
        ack_result(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
